// File: rtl/pll_pwr_cal_ctrl_if.sv
// Signal bundle between the PLL power/trim controller and its environment
// (SPI configuration on one side, PLL analog enables/trim/feedback on the other).
interface pll_pwr_cal_ctrl_if;
   logic       pll_enable;
   logic       trim_ovr;
   logic [3:0] spi_trim;
   logic       fb_tick;
   logic       pll_bias_ena;
   logic       pll_cp_ena;
   logic       pll_vco_ena;
   logic [3:0] pll_trim;
   logic       busy;
   logic       locked;
   logic       cal_error;

   modport master (
      input  pll_enable,
      input  trim_ovr,
      input  spi_trim,
      input  fb_tick,
      output pll_bias_ena,
      output pll_cp_ena,
      output pll_vco_ena,
      output pll_trim,
      output busy,
      output locked,
      output cal_error
   );

   modport slave (
      output pll_enable,
      output trim_ovr,
      output spi_trim,
      output fb_tick,
      input  pll_bias_ena,
      input  pll_cp_ena,
      input  pll_vco_ena,
      input  pll_trim,
      input  busy,
      input  locked,
      input  cal_error
   );
endinterface

// File: rtl/pll_pwr_cal_ctrl.sv
// PLL power-up sequencer: timed bias/CP/VCO enables, then a 4-bit binary search
// of the VCO trim by counting feedback ticks per reference window, then a verify.
module pll_pwr_cal_ctrl #(
   parameter int BIAS_WAIT = 64,
   parameter int CP_WAIT   = 32,
   parameter int VCO_WAIT  = 256,
   parameter int WINDOW    = 1024,
   parameter int TARGET    = 512,
   parameter int TOL       = 4,
   parameter int CW        = 16
) (
   input logic                CLK,
   input logic                RST,
   pll_pwr_cal_ctrl_if.master pll
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BIAS,
      S_CP,
      S_VCO,
      S_CAL,
      S_VERIFY,
      S_DONE,
      S_FAIL
   } state_t;

   localparam logic [CW-1:0] BIAS_LAST = CW'(BIAS_WAIT - 1);
   localparam logic [CW-1:0] CP_LAST   = CW'(CP_WAIT - 1);
   localparam logic [CW-1:0] VCO_LAST  = CW'(VCO_WAIT - 1);
   localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);
   localparam logic [CW-1:0] TARGET_C  = CW'(TARGET);
   localparam logic [CW-1:0] TARGET_LO = CW'(TARGET - TOL);
   localparam logic [CW-1:0] TARGET_HI = CW'(TARGET + TOL);
   localparam logic [CW-1:0] TICK_MAX  = {CW{1'b1}};
   localparam logic [3:0]    TRIM_MID  = 4'b1000;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [CW-1:0] tick_reg, tick_next;
   logic [1:0]    bit_reg, bit_next;
   logic          decide_reg, decide_next;
   logic [3:0]    trim_reg, trim_next;
   logic          bias_reg, bias_next;
   logic          cp_reg, cp_next;
   logic          vco_reg, vco_next;
   logic          busy_reg, busy_next;
   logic          locked_reg, locked_next;
   logic          error_reg, error_next;

   logic win_last;
   logic tick_above;
   logic tick_in_tol;

   assign win_last    = (cnt_reg == WIN_LAST);
   assign tick_above  = (tick_reg > TARGET_C);
   assign tick_in_tol = (tick_reg >= TARGET_LO) && (tick_reg <= TARGET_HI);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         tick_reg   <= '0;
         bit_reg    <= 2'd3;
         decide_reg <= 1'b0;
         trim_reg   <= TRIM_MID;
         bias_reg   <= 1'b0;
         cp_reg     <= 1'b0;
         vco_reg    <= 1'b0;
         busy_reg   <= 1'b0;
         locked_reg <= 1'b0;
         error_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         tick_reg   <= tick_next;
         bit_reg    <= bit_next;
         decide_reg <= decide_next;
         trim_reg   <= trim_next;
         bias_reg   <= bias_next;
         cp_reg     <= cp_next;
         vco_reg    <= vco_next;
         busy_reg   <= busy_next;
         locked_reg <= locked_next;
         error_reg  <= error_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      tick_next   = tick_reg;
      bit_next    = bit_reg;
      decide_next = decide_reg;
      trim_next   = trim_reg;
      bias_next   = bias_reg;
      cp_next     = cp_reg;
      vco_next    = vco_reg;
      busy_next   = 1'b0;
      locked_next = 1'b0;
      error_next  = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (pll.pll_enable) begin
               state_next = S_BIAS;
               bias_next  = 1'b1;
               cnt_next   = '0;
            end
         end

         S_BIAS: begin
            if (cnt_reg == BIAS_LAST) begin
               state_next = S_CP;
               cp_next    = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         S_CP: begin
            if (cnt_reg == CP_LAST) begin
               state_next = S_VCO;
               vco_next   = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         S_VCO: begin
            if (cnt_reg == VCO_LAST) begin
               cnt_next    = '0;
               tick_next   = '0;
               decide_next = 1'b0;
               // Override choice is latched only here; later changes wait for the next power-up.
               if (pll.trim_ovr) begin
                  trim_next  = pll.spi_trim;
                  state_next = S_DONE;
               end else begin
                  trim_next  = TRIM_MID;
                  bit_next   = 2'd3;
                  state_next = S_CAL;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         S_CAL, S_VERIFY: begin
            if (!decide_reg) begin
               if (pll.fb_tick && (tick_reg != TICK_MAX)) begin
                  tick_next = tick_reg + 1'b1;
               end
               if (win_last) begin
                  cnt_next    = '0;
                  decide_next = 1'b1;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end else begin
               // Decision cycle: ticks arriving here belong to no window.
               decide_next = 1'b0;
               tick_next   = '0;
               cnt_next    = '0;
               if (state_reg == S_CAL) begin
                  if (tick_above) begin
                     trim_next[bit_reg] = 1'b0;
                  end
                  if (bit_reg == 2'd0) begin
                     state_next = S_VERIFY;
                  end else begin
                     trim_next[bit_reg - 2'd1] = 1'b1;
                     bit_next = bit_reg - 2'd1;
                  end
               end else begin
                  state_next = tick_in_tol ? S_DONE : S_FAIL;
               end
            end
         end

         S_DONE, S_FAIL: begin
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Power-down wins over everything: all enables drop together.
      if ((state_reg != S_IDLE) && !pll.pll_enable) begin
         state_next  = S_IDLE;
         cnt_next    = '0;
         tick_next   = '0;
         bit_next    = 2'd3;
         decide_next = 1'b0;
         trim_next   = TRIM_MID;
         bias_next   = 1'b0;
         cp_next     = 1'b0;
         vco_next    = 1'b0;
      end

      busy_next   = !(state_next inside {S_IDLE, S_DONE, S_FAIL});
      locked_next = (state_next == S_DONE);
      error_next  = (state_next == S_FAIL);
   end

   assign pll.pll_bias_ena = bias_reg;
   assign pll.pll_cp_ena   = cp_reg;
   assign pll.pll_vco_ena  = vco_reg;
   assign pll.pll_trim     = trim_reg;
   assign pll.busy         = busy_reg;
   assign pll.locked       = locked_reg;
   assign pll.cal_error    = error_reg;

endmodule

// File: doc/pll_pwr_cal_ctrl.md
Name: pll_pwr_cal_ctrl

Overview:
Power-up sequencer and trim calibrator for the on-chip PLL analog core. It drives the bias, charge-pump and VCO enables in a timed order. It then binary-searches the 4-bit VCO trim by counting divided-feedback ticks over a fixed reference window. It sits between the SPI configuration registers (enable, manual trim override) and the PLL analog enables/trim pins.

Parameters:
BIAS_WAIT, 64, CLK cycles from bias enable to charge-pump enable
CP_WAIT, 32, CLK cycles from charge-pump enable to VCO enable
VCO_WAIT, 256, CLK cycles of VCO settling before calibration/done
WINDOW, 1024, CLK cycles per frequency measurement window
TARGET, 512, expected feedback tick count per window
TOL, 4, max |count-TARGET| accepted in final verify
CW, 16, width of wait/window/tick counters (tick counter saturates at 2^CW-1)

Ports:
CLK  input  1  system clock; all state on rising edge
RST  input  1  asynchronous, active-low reset
pll_enable  input  1  level; 1 = bring PLL up, 0 = power down
trim_ovr  input  1  level, sampled in VCO_WAIT exit; 1 = skip calibration, use spi_trim
spi_trim  input  4  manual trim value used when trim_ovr=1
fb_tick  input  1  single-cycle pulse per divided VCO edge, already synchronized to CLK
pll_bias_ena  output  1  PLL bias enable
pll_cp_ena  output  1  PLL charge-pump enable
pll_vco_ena  output  1  PLL VCO enable
pll_trim  output  4  PLL VCO trim code
busy  output  1  1 in any state other than IDLE, DONE, FAIL
locked  output  1  1 only in DONE
cal_error  output  1  1 only in FAIL

Behaviour:
- Reset (RST=0, async): state IDLE; all enables 0; pll_trim=4'b1000; busy/locked/cal_error 0; all counters 0.
- All outputs are registered; no combinational path from input to output.
- IDLE: when pll_enable=1, go to BIAS next cycle with pll_bias_ena=1.
- BIAS: hold for BIAS_WAIT cycles, then go to CP with pll_cp_ena=1.
- CP: hold for CP_WAIT cycles, then go to VCO with pll_vco_ena=1.
- VCO: hold for VCO_WAIT cycles, then branch on trim_ovr:
  - trim_ovr=1: pll_trim=spi_trim, go to DONE.
  - trim_ovr=0: go to CAL with bit index i=3 and pll_trim=4'b1000.
- Enable ordering: bias ≤ cp ≤ vco at all times; no enable ever asserts before its predecessor.
- CAL (one step per bit, i=3..0):
  - Window counter runs WINDOW cycles; tick counter counts fb_tick in those cycles, including a tick on the last cycle.
  - One decision cycle follows: if count > TARGET, clear pll_trim[i]; if i>0, set pll_trim[i-1] and i--. Counters clear.
  - After bit 0 is decided, go to VERIFY.
- VERIFY: measure one more window with the final trim. If |count-TARGET| ≤ TOL go to DONE, else go to FAIL.
- Full calibration takes exactly 5*(WINDOW+1) cycles from CAL entry to DONE/FAIL.
- DONE: locked=1; trim and enables held; the block stays here while pll_enable=1.
- FAIL: cal_error=1; enables and trim held; the block stays here while pll_enable=1.
- pll_enable=0 in any non-IDLE state, including mid-wait or mid-window: next cycle IDLE, all enables 0 simultaneously, pll_trim=4'b1000, flags 0, counters cleared. A pll_enable=1 must then restart from BIAS.
- trim_ovr/spi_trim changes outside the VCO exit cycle are ignored until the next power-up.
- Tick counter saturates at 2^CW-1 and never wraps.

Test Plan:
- Power-up timing: reset, pll_enable=1, trim_ovr=1, spi_trim=4'b0101 -> bias rises 1 cycle after enable, cp 64 later, vco 32 later; 256 later pll_trim=0101 and locked=1, with busy=1 throughout up to that point.
- Calibration convergence: fb model gives trim*64 ticks per window -> bit decisions keep/clear/clear/clear; final pll_trim=4'b1000, VERIFY count 512, locked=1 exactly 5*1025 cycles after CAL entry.
- No feedback: fb_tick stuck 0 -> trim walks to 4'b1111, VERIFY count 0, cal_error=1, locked=0, enables still 1.
- Abort mid-calibration: drop pll_enable during the bit-1 window -> next cycle all enables 0, trim 4'b1000, busy 0. Re-enable -> full sequence restarts from BIAS.
- Async reset: assert RST=0 mid-way through the CP wait (between clock edges) -> outputs go to reset values immediately, without waiting for a CLK edge.
- Tick on the window boundary: fb model yields 513 ticks, the last on window cycle WINDOW-1 -> counted, bit cleared.
